// File: rtl/uart_mem_bridge_ctrl.sv
// uart_mem_bridge_ctrl: turns picorv32 native-bus requests into UART byte bursts
// (cmd, addr, wdata) and reassembles 4-byte read replies from the host.
//
// state | meaning
// IDLE  | waiting for mem_valid_i; rx bytes arriving here are dropped as strays
// CMD   | sending the command byte
// ADDR  | sending address bytes, LSB first
// WDATA | sending write data bytes, LSB first
// RDATA | collecting reply bytes, inter-byte timeout armed
// DONE  | one-cycle mem_ready_o pulse with mem_rdata_o
module uart_mem_bridge_ctrl #(
  parameter int unsigned TimeoutCycles = 1_000_000,
  parameter logic [31:0] TimeoutData   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_valid_i,
  input  logic        mem_instr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        busy_o,
  output logic        stray_o,
  output logic        timeout_o
);

  localparam bit          TO_EN   = (TimeoutCycles != 0);
  localparam logic [31:0] TO_LOAD = TO_EN ? 32'(TimeoutCycles - 1) : 32'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_to_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_is_wr;
  logic [23:0] r_rdata;
  logic        r_mem_ready;
  logic [31:0] r_mem_rdata;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_rx_ready;
  logic        r_busy;
  logic        r_stray;
  logic        r_timeout;

  logic        w_tx_hs;
  logic        w_rx_hs;
  logic [1:0]  w_cnt_nxt;

  assign w_tx_hs   = r_tx_valid & tx_ready_i;
  assign w_rx_hs   = r_rx_ready & rx_valid_i;
  assign w_cnt_nxt = r_cnt + 2'd1;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_to_cnt    <= 32'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_is_wr     <= 1'b0;
      r_rdata     <= 24'd0;
      r_mem_ready <= 1'b0;
      r_mem_rdata <= 32'd0;
      r_tx_data   <= 8'd0;
      r_tx_valid  <= 1'b0;
      r_rx_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_stray     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_stray <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rx_ready <= 1'b1;
          if (w_rx_hs) r_stray <= 1'b1;
          if (mem_valid_i) begin
            r_addr     <= mem_addr_i;
            r_wdata    <= mem_wdata_i;
            r_is_wr    <= |mem_wstrb_i;
            r_tx_data  <= {|mem_wstrb_i, mem_instr_i, 2'b00, mem_wstrb_i};
            r_tx_valid <= 1'b1;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_cnt      <= 2'd0;
            r_state    <= S_CMD;
          end
        end

        S_CMD: begin
          if (w_tx_hs) begin
            r_tx_data <= byte_sel(r_addr, 2'd0);
            r_cnt     <= 2'd0;
            r_state   <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (w_tx_hs) begin
            r_cnt <= w_cnt_nxt;
            if (r_cnt == 2'd3) begin
              if (r_is_wr) begin
                r_tx_data <= byte_sel(r_wdata, 2'd0);
                r_state   <= S_WDATA;
              end else begin
                r_tx_valid <= 1'b0;
                r_tx_data  <= 8'd0;
                r_rx_ready <= 1'b1;
                r_to_cnt   <= TO_LOAD;
                r_rdata    <= 24'd0;
                r_state    <= S_RDATA;
              end
            end else begin
              r_tx_data <= byte_sel(r_addr, w_cnt_nxt);
            end
          end
        end

        S_WDATA: begin
          if (w_tx_hs) begin
            r_cnt <= w_cnt_nxt;
            if (r_cnt == 2'd3) begin
              r_tx_valid  <= 1'b0;
              r_tx_data   <= 8'd0;
              r_mem_ready <= 1'b1;
              r_mem_rdata <= 32'd0;
              r_state     <= S_DONE;
            end else begin
              r_tx_data <= byte_sel(r_wdata, w_cnt_nxt);
            end
          end
        end

        // A byte arriving in the expiry cycle takes priority over the timeout.
        S_RDATA: begin
          if (w_rx_hs) begin
            r_cnt    <= w_cnt_nxt;
            r_to_cnt <= TO_LOAD;
            case (r_cnt)
              2'd0: r_rdata[7:0]   <= rx_data_i;
              2'd1: r_rdata[15:8]  <= rx_data_i;
              2'd2: r_rdata[23:16] <= rx_data_i;
              default: begin
                r_mem_rdata <= {rx_data_i, r_rdata};
                r_mem_ready <= 1'b1;
                r_rx_ready  <= 1'b0;
                r_state     <= S_DONE;
              end
            endcase
          end else if (TO_EN && (r_to_cnt == 32'd0)) begin
            r_mem_rdata <= TimeoutData;
            r_mem_ready <= 1'b1;
            r_timeout   <= 1'b1;
            r_rx_ready  <= 1'b0;
            r_cnt       <= 2'd0;
            r_state     <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt - 32'd1;
          end
        end

        S_DONE: begin
          r_mem_ready <= 1'b0;
          r_mem_rdata <= 32'd0;
          r_busy      <= 1'b0;
          r_rx_ready  <= 1'b1;
          r_cnt       <= 2'd0;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_ready_o = r_mem_ready;
  assign mem_rdata_o = r_mem_rdata;
  assign tx_data_o   = r_tx_data;
  assign tx_valid_o  = r_tx_valid;
  assign rx_ready_o  = r_rx_ready;
  assign busy_o      = r_busy;
  assign stray_o     = r_stray;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_uart_mem_bridge_ctrl.sv
// Bench for uart_mem_bridge_ctrl: drives CPU and host sides per cycle and compares
// against a byte-stream model of each bus request.
module tb_uart_mem_bridge_ctrl;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] TO_DATA = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        mem_valid_i;
  logic        mem_instr_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic        mem_ready_o;
  logic [31:0] mem_rdata_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        busy_o;
  logic        stray_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_timeout = 1'b0;

  always #5 clk_i = ~clk_i;

  uart_mem_bridge_ctrl #(
    .TimeoutCycles(TIMEOUT),
    .TimeoutData  (TO_DATA)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .mem_valid_i(mem_valid_i),
    .mem_instr_i(mem_instr_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_wstrb_i(mem_wstrb_i),
    .mem_ready_o(mem_ready_o),
    .mem_rdata_o(mem_rdata_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .busy_o     (busy_o),
    .stray_o    (stray_o),
    .timeout_o  (timeout_o)
  );

  // One bus request end to end. stall_mode: 0 always ready, 1 ready one cycle in three,
  // 2 random. rx_gap: idle RDATA cycles before each reply byte, -1 = random 0..3.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr,
                         input logic [31:0] reply, input int nreply,
                         input int stall_mode, input int rx_gap,
                         input bit early_rx, input bit scramble, input string name);
    logic [7:0]  exp_tx[$];
    logic [7:0]  got_tx[$];
    logic [31:0] exp_rdata;
    logic [31:0] got_rdata;
    logic [7:0]  prev_data;
    bit          is_wr, done, prev_stall;
    int          it, hs_rx, idle, gap, ready_it, last_rx_it, exp_rx;

    is_wr = (wstrb != 4'h0);
    exp_tx.push_back({is_wr, instr, 2'b00, wstrb});
    for (int i = 0; i < 4; i++) exp_tx.push_back(addr[8*i +: 8]);
    if (is_wr) for (int i = 0; i < 4; i++) exp_tx.push_back(wdata[8*i +: 8]);
    if (is_wr)            exp_rdata = 32'd0;
    else if (nreply >= 4) exp_rdata = reply;
    else                  exp_rdata = TO_DATA;
    if (!is_wr && nreply < 4) exp_timeout = 1'b1;
    exp_rx = is_wr ? 0 : ((nreply < 4) ? nreply : 4);

    done = 1'b0; prev_stall = 1'b0; prev_data = 8'd0;
    it = 0; hs_rx = 0; idle = 0; ready_it = -1; last_rx_it = -1;
    got_rdata = 32'd0;
    gap = (rx_gap < 0) ? int'($urandom_range(0, 3)) : rx_gap;

    while (!done && it < 400) begin
      @(negedge clk_i);
      if (it == 0) begin
        n_checks++;
        if ({mem_ready_o, busy_o} !== 2'b00)
          $display("FAIL %s.idle_at_start ready/busy=%b expected 00", name, {mem_ready_o, busy_o});
        else n_pass++;
        mem_valid_i = 1'b1; mem_addr_i = addr; mem_wdata_i = wdata;
        mem_wstrb_i = wstrb; mem_instr_i = instr;
      end else begin
        if (mem_ready_o) begin
          done = 1'b1; ready_it = it; got_rdata = mem_rdata_o;
        end
        if (prev_stall) begin
          n_checks++;
          if (tx_valid_o !== 1'b1 || tx_data_o !== prev_data)
            $display("FAIL %s.tx_hold valid=%b data=%02h expected 1/%02h", name, tx_valid_o, tx_data_o, prev_data);
          else n_pass++;
        end
        if (scramble && busy_o) begin
          mem_valid_i = ($urandom_range(0, 1) == 1);
          mem_addr_i = $urandom; mem_wdata_i = $urandom;
          mem_wstrb_i = 4'($urandom); mem_instr_i = ($urandom_range(0, 1) == 1);
        end
      end

      case (stall_mode)
        0:       tx_ready_i = 1'b1;
        1:       tx_ready_i = (it % 3 == 0);
        default: tx_ready_i = ($urandom_range(0, 1) == 1);
      endcase
      if (tx_valid_o && tx_ready_i) got_tx.push_back(tx_data_o);
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_data  = tx_data_o;

      rx_valid_i = 1'b0;
      if (busy_o && !done && hs_rx < nreply) begin
        if (rx_ready_o) begin
          if (idle >= gap) begin
            rx_valid_i = 1'b1; rx_data_i = reply[8*hs_rx +: 8];
          end else idle++;
        end else if (early_rx) begin
          rx_valid_i = 1'b1; rx_data_i = reply[8*hs_rx +: 8];
        end
      end
      if (rx_valid_i && rx_ready_o) begin
        n_checks++;
        if (got_tx.size() != exp_tx.size())
          $display("FAIL %s.rx_before_tx_done tx_sent=%0d expected %0d", name, got_tx.size(), exp_tx.size());
        else n_pass++;
        hs_rx++; idle = 0; last_rx_it = it;
        gap = (rx_gap < 0) ? int'($urandom_range(0, 3)) : rx_gap;
      end
      it++;
    end
    rx_valid_i = 1'b0;

    n_checks++;
    if (!done) $display("FAIL %s.mem_ready_timeout no ready after %0d cycles", name, it);
    else n_pass++;
    if (done) begin
      n_checks++;
      if (got_tx.size() != exp_tx.size())
        $display("FAIL %s.tx_count got %0d expected %0d", name, got_tx.size(), exp_tx.size());
      else n_pass++;
      for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
        n_checks++;
        if (got_tx[i] !== exp_tx[i])
          $display("FAIL %s.tx_byte%0d got %02h expected %02h", name, i, got_tx[i], exp_tx[i]);
        else n_pass++;
      end
      n_checks++;
      if (got_rdata !== exp_rdata)
        $display("FAIL %s.rdata got %08h expected %08h", name, got_rdata, exp_rdata);
      else n_pass++;
      n_checks++;
      if (hs_rx != exp_rx)
        $display("FAIL %s.rx_consumed got %0d expected %0d", name, hs_rx, exp_rx);
      else n_pass++;
      n_checks++;
      if (timeout_o !== exp_timeout)
        $display("FAIL %s.timeout_flag got %b expected %b", name, timeout_o, exp_timeout);
      else n_pass++;
      if (stall_mode == 0 && rx_gap == 0 && (is_wr || nreply >= 4)) begin
        n_checks++;
        if (ready_it != 1 + exp_tx.size() + exp_rx)
          $display("FAIL %s.latency got %0d expected %0d", name, ready_it, 1 + exp_tx.size() + exp_rx);
        else n_pass++;
      end
      if (!is_wr && nreply > 0 && nreply < 4) begin
        n_checks++;
        if (ready_it - last_rx_it != TIMEOUT + 1)
          $display("FAIL %s.timeout_delay got %0d expected %0d", name, ready_it - last_rx_it, TIMEOUT + 1);
        else n_pass++;
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk_i);
    mem_valid_i = 1'b0; tx_ready_i = 1'b1; rx_valid_i = 1'b0;
    n_checks++;
    if ({mem_ready_o, busy_o} !== 2'b00)
      $display("FAIL idle.ready_pulse_len ready/busy=%b expected 00", {mem_ready_o, busy_o});
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; mem_valid_i = 1'b0; mem_instr_i = 1'b0; mem_addr_i = 32'd0;
    mem_wdata_i = 32'd0; mem_wstrb_i = 4'd0; tx_ready_i = 1'b0;
    rx_data_i = 8'd0; rx_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({mem_ready_o, tx_valid_o, rx_ready_o, busy_o, stray_o, timeout_o} !== 6'b0)
      $display("FAIL reset.flags got %b expected 000000",
               {mem_ready_o, tx_valid_o, rx_ready_o, busy_o, stray_o, timeout_o});
    else n_pass++;
    n_checks++;
    if ({mem_rdata_o, tx_data_o} !== 40'd0)
      $display("FAIL reset.data got %08h/%02h expected 0/0", mem_rdata_o, tx_data_o);
    else n_pass++;
    reset_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({rx_ready_o, busy_o} !== 2'b10)
      $display("FAIL reset.idle rx_ready/busy=%b expected 10", {rx_ready_o, busy_o});
    else n_pass++;
  endtask

  task automatic test_write();
    run_txn(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 0, 0, 0, 1'b1, 1'b0, "write");
    idle_cycle();
  endtask

  task automatic test_fetch();
    run_txn(32'h0000_0004, 32'h0, 4'h0, 1'b1, 32'h0000_0513, 4, 0, 0, 1'b1, 1'b0, "fetch");
    idle_cycle();
  endtask

  task automatic test_tx_stall();
    run_txn($urandom, $urandom, 4'h3, 1'b0, 32'h0, 0, 1, 0, 1'b0, 1'b0, "stall_wr");
    idle_cycle();
    run_txn($urandom, 32'h0, 4'h0, 1'b0, $urandom, 4, 1, 0, 1'b1, 1'b0, "stall_rd");
    idle_cycle();
  endtask

  task automatic test_stray();
    @(negedge clk_i);
    mem_valid_i = 1'b0; rx_valid_i = 1'b1; rx_data_i = 8'h55;
    n_checks++;
    if (rx_ready_o !== 1'b1) $display("FAIL stray.rx_ready got %b expected 1", rx_ready_o);
    else n_pass++;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    n_checks++;
    if ({stray_o, busy_o} !== 2'b10)
      $display("FAIL stray.pulse stray/busy=%b expected 10", {stray_o, busy_o});
    else n_pass++;
    @(negedge clk_i);
    n_checks++;
    if (stray_o !== 1'b0) $display("FAIL stray.one_cycle got %b expected 0", stray_o);
    else n_pass++;
    run_txn($urandom, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, 4, 0, 0, 1'b0, 1'b0, "after_stray");
    idle_cycle();
  endtask

  task automatic test_rx_race();
    run_txn($urandom, 32'h0, 4'h0, 1'b0, $urandom, 4, 0, TIMEOUT - 1, 1'b0, 1'b0, "slow_reply");
    idle_cycle();
  endtask

  task automatic test_timeout();
    run_txn($urandom, 32'h0, 4'h0, 1'b1, 32'h0000_ABCD, 2, 0, 0, 1'b1, 1'b0, "timeout");
    idle_cycle();
    run_txn($urandom, 32'h0, 4'h0, 1'b0, $urandom, 4, 0, 0, 1'b1, 1'b0, "after_timeout");
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    int hs;
    int it;
    int leaked;
    hs = 0; it = 0; leaked = 0;
    @(negedge clk_i);
    mem_valid_i = 1'b1; mem_addr_i = $urandom; mem_wstrb_i = 4'h0; mem_instr_i = 1'b0;
    tx_ready_i = 1'b1; rx_valid_i = 1'b0;
    while (hs < 4 && it < 50) begin
      @(negedge clk_i);
      it++;
      if (busy_o) mem_valid_i = 1'b0;
      if (tx_valid_o && tx_ready_i) hs++;
    end
    n_checks++;
    if (hs != 4) $display("FAIL reset_mid.reach_addr handshakes=%0d expected 4", hs);
    else n_pass++;
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    exp_timeout = 1'b0;
    n_checks++;
    if ({tx_valid_o, busy_o, mem_ready_o, timeout_o} !== 4'b0)
      $display("FAIL reset_mid.abandon valid/busy/ready/timeout=%b expected 0000",
               {tx_valid_o, busy_o, mem_ready_o, timeout_o});
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (tx_valid_o) leaked++;
    end
    n_checks++;
    if (leaked != 0) $display("FAIL reset_mid.no_more_tx got %0d bytes expected 0", leaked);
    else n_pass++;
    run_txn($urandom, 32'h0, 4'h0, 1'b0, $urandom, 4, 0, 0, 1'b1, 1'b0, "after_reset");
    idle_cycle();
  endtask

  task automatic test_random_back_to_back();
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a, d, r;
      logic [3:0]  s;
      logic        ins;
      int          sm, gp;
      bit          er, sc;
      a = $urandom; d = $urandom; r = $urandom;
      s   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      ins = ($urandom_range(0, 1) == 1);
      sm  = int'($urandom_range(0, 2));
      gp  = ($urandom_range(0, 1) == 1) ? -1 : 0;
      er  = ($urandom_range(0, 1) == 1);
      sc  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) idle_cycle();
      run_txn(a, d, s, ins, r, 4, sm, gp, er, sc, "random");
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_write();
    test_fetch();
    test_tx_stall();
    test_stray();
    test_rx_race();
    test_timeout();
    test_reset_mid();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
